branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and branch-resolution unit for the 5-stage MIPS pipeline. In IF it supplies a taken/not-taken prediction per fetch PC, which travels down the pipe with the branch flags into EX. In EX it takes back the resolved outcome, trains a table of 2-bit saturating counters, and on a wrong prediction raises a redirect with the correct PC so IF/ID and ID/EX can be flushed. It also keeps saturating branch and miss counters for performance measurement.

## Interface
Parameters:
- IDX_W, 6, table index width; table holds 2^IDX_W two-bit counters.
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).
- STAT_W, 16, width of each statistics counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_0  in  1  asynchronous, active-low reset.
- pc_if  in  32  PC of the instruction being fetched.
- taken_if  out  1  prediction for pc_if; bit 1 of the indexed counter; combinational.
- pc_ex  in  32  PC of the instruction in EX.
- target_ex  in  32  branch target computed in EX.
- bp_isbranch_ex  in  1  instruction in EX is a conditional branch.
- bp_taken_ex  in  1  prediction made for this instruction in IF.
- actual_taken_ex  in  1  branch condition resolved in EX.
- valid_ex  in  1  EX holds a real instruction and is advancing this cycle (not a stall or bubble).
- redirect  out  1  misprediction; flush IF/ID and ID/EX and load redirect_pc; combinational.
- redirect_pc  out  32  corrected fetch PC; combinational.
- branch_cnt  out  STAT_W  resolved branches, saturating.
- miss_cnt  out  STAT_W  mispredicted branches, saturating.

## Operation
- Index: idx_if = pc_if[IDX_W+1:2] and idx_ex = pc_ex[IDX_W+1:2]. No tags; aliasing is allowed.
- Resolve: res = valid_ex & bp_isbranch_ex.
- Misprediction:
  - redirect = res & (bp_taken_ex != actual_taken_ex).
  - redirect_pc = target_ex when actual_taken_ex is 1, otherwise pc_ex + 4 (32-bit add, wraps modulo 2^32).
  - When redirect is 0, redirect_pc still carries that value; it is don't-care.
- Training happens on the rising edge when res is 1:
  - If actual_taken_ex is 1, counter[idx_ex] = min(counter + 1, 3).
  - If actual_taken_ex is 0, counter[idx_ex] = max(counter - 1, 0).
  - Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Statistics, on the rising edge:
  - When res is 1, branch_cnt increments.
  - When redirect is 1, miss_cnt increments.
  - Both hold at all-ones and never wrap.
- Non-branches, bubbles and stalls (res = 0) change no state.
- bp_taken_ex is used only for the miss comparison. The table is never re-read in EX.

## Timing
- Reset (asynchronous, on reset_0 low, takes effect immediately):
  - Every counter = CNT_INIT, so taken_if = CNT_INIT[1] = 0 for every pc_if.
  - branch_cnt = 0, miss_cnt = 0.
  - redirect is 0 whenever valid_ex is 0.
- Reset asserted mid-operation discards all training at once. The first rising edge after reset_0 returns high may train normally.
- Lookup latency: 0 cycles. taken_if follows pc_if combinationally from the current table contents.
- Update latency: a write in cycle N is visible on taken_if from cycle N+1.
- Same index read and written in one cycle (idx_if == idx_ex with res = 1): taken_if returns the pre-update value. There is no bypass.
- redirect and redirect_pc are valid in the same cycle as the branch's EX stage. The flush takes effect on the next edge in the pipeline registers, not here.
- Exactly one table write per cycle at most. Stalls must hold valid_ex low on repeated cycles so a branch trains only once.

## Test plan
- Reset, then sweep pc_if over 0x0..0xFC -> taken_if = 0 everywhere; branch_cnt = miss_cnt = 0.
- Train pc_ex = 0x40 with actual_taken_ex = 1 on two cycles (bp_taken_ex = 0 each time):
  - redirect = 1 with redirect_pc = target_ex = 0x100 on both cycles.
  - Afterwards, taken_if for pc_if = 0x40 is 1 and the counter is 11.
  - miss_cnt = 2, branch_cnt = 2.
- Saturation: pc_ex = 0x40 not-taken five times from 11 -> counter goes 10, 01, 00, 00, 00. redirect_pc = 0x44 on each not-taken miss.
- Same-cycle hazard: pc_if = pc_ex = 0x80, counter 01, res = 1, actual taken -> taken_if = 0 in that cycle and 1 in the next.
- valid_ex = 0 with bp_isbranch_ex = 1 and mismatched prediction -> redirect = 0, no counter or statistics change. Assert reset_0 mid-training -> all predictions return to 0 immediately.
- Statistics saturation with STAT_W = 4: 20 mispredicted branches -> branch_cnt = miss_cnt = 4'hF, and they hold there.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor signal bundle: IF lookup, EX resolution/redirect, statistics.
interface branch_predictor_if #(
  parameter int unsigned STAT_W = 16
);
  logic [31:0]       pc_if;
  logic              taken_if;
  logic [31:0]       pc_ex;
  logic [31:0]       target_ex;
  logic              bp_isbranch_ex;
  logic              bp_taken_ex;
  logic              actual_taken_ex;
  logic              valid_ex;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] miss_cnt;

  modport master (
    output pc_if, pc_ex, target_ex, bp_isbranch_ex, bp_taken_ex, actual_taken_ex, valid_ex,
    input  taken_if, redirect, redirect_pc, branch_cnt, miss_cnt
  );

  modport slave (
    input  pc_if, pc_ex, target_ex, bp_isbranch_ex, bp_taken_ex, actual_taken_ex, valid_ex,
    output taken_if, redirect, redirect_pc, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch predictor with EX-stage resolution, redirect and
// saturating branch/miss statistics.
module branch_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01,
  parameter int unsigned STAT_W   = 16
) (
  input logic               clock,
  input logic               reset_0,
  branch_predictor_if.slave bp
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0]        table_q [DEPTH];
  logic [IDX_W-1:0]  idx_if;
  logic [IDX_W-1:0]  idx_ex;
  logic              res;
  logic              miss;
  logic [31:0]       fallthru_pc;
  logic [STAT_W-1:0] branch_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;
  logic              unused_pc_bits;

  assign idx_if = bp.pc_if[IDX_W+1:2];
  assign idx_ex = bp.pc_ex[IDX_W+1:2];
  assign unused_pc_bits = &{1'b0, bp.pc_if[31:IDX_W+2], bp.pc_if[1:0]};

  always_comb begin
    res         = bp.valid_ex & bp.bp_isbranch_ex;
    miss        = res & (bp.bp_taken_ex != bp.actual_taken_ex);
    fallthru_pc = bp.pc_ex + 32'd4;
  end

  // Lookup reads the registered table only, so a same-cycle write is not bypassed.
  assign bp.taken_if    = table_q[idx_if][1];
  assign bp.redirect    = miss;
  assign bp.redirect_pc = bp.actual_taken_ex ? bp.target_ex : fallthru_pc;
  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.miss_cnt    = miss_cnt_q;

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= CNT_INIT;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (res) begin
        if (bp.actual_taken_ex) begin
          if (table_q[idx_ex] != 2'b11) table_q[idx_ex] <= table_q[idx_ex] + 2'd1;
        end else begin
          if (table_q[idx_ex] != 2'b00) table_q[idx_ex] <= table_q[idx_ex] - 2'd1;
        end
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (statistics width 4 to reach saturation).
module tb_branch_predictor;
  logic clock;
  logic reset_0;
  int   n_cmp;
  int   n_fail;

  branch_predictor_if #(.STAT_W(4)) bp_bus ();

  branch_predictor #(.IDX_W(6), .CNT_INIT(2'b01), .STAT_W(4)) dut (
    .clock   (clock),
    .reset_0 (reset_0),
    .bp      (bp_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc_if;
    logic [31:0] pc_ex;
    logic [31:0] tgt;
    logic        br;
    logic        bpt;
    logic        act;
    logic        vld;
    logic        exp_t;
    logic        exp_r;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc_if, input logic [31:0] pc_ex, input logic [31:0] tgt,
                       input logic br, input logic bpt, input logic act, input logic vld);
    bp_bus.pc_if           = pc_if;
    bp_bus.pc_ex           = pc_ex;
    bp_bus.target_ex       = tgt;
    bp_bus.bp_isbranch_ex  = br;
    bp_bus.bp_taken_ex     = bpt;
    bp_bus.actual_taken_ex = act;
    bp_bus.valid_ex        = vld;
  endtask

  function automatic vec_t mk(input logic [31:0] pc_if, input logic [31:0] pc_ex, input logic [31:0] tgt,
                              input logic br, input logic bpt, input logic act, input logic vld,
                              input logic exp_t, input logic exp_r, input logic [31:0] exp_pc);
    vec_t v;
    v.pc_if = pc_if; v.pc_ex = pc_ex; v.tgt = tgt; v.br = br; v.bpt = bpt; v.act = act; v.vld = vld;
    v.exp_t = exp_t; v.exp_r = exp_r; v.exp_pc = exp_pc;
    return v;
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //            pc_if     pc_ex         tgt       br bpt act vld  t  r  rpc
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 0, 1, 1,   0, 1, 32'h100));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 0, 1, 1,   1, 1, 32'h100));
    vecs.push_back(mk(32'h40, 32'h0,        32'h0,   0, 0, 0, 1,   1, 0, 32'h4));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 1, 0, 1,   1, 1, 32'h44));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 1, 0, 1,   1, 1, 32'h44));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 1, 0, 1,   0, 1, 32'h44));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 1, 0, 1,   0, 1, 32'h44));
    vecs.push_back(mk(32'h40, 32'h40,       32'h100, 1, 1, 0, 1,   0, 1, 32'h44));
    vecs.push_back(mk(32'h40, 32'h0,        32'h0,   0, 0, 0, 1,   0, 0, 32'h4));
    vecs.push_back(mk(32'hFC, 32'hFFFFFFFC, 32'h0,   1, 1, 0, 1,   0, 1, 32'h0));
    vecs.push_back(mk(32'h10, 32'h10,       32'h800, 1, 0, 0, 1,   0, 0, 32'h14));
    vecs.push_back(mk(32'h10, 32'h20,       32'h300, 1, 1, 1, 1,   0, 0, 32'h300));
    vecs.push_back(mk(32'h120, 32'h10,      32'h500, 0, 0, 1, 1,   1, 0, 32'h500));
    vecs.push_back(mk(32'h20, 32'h10,       32'h500, 0, 0, 1, 1,   1, 0, 32'h500));
    vecs.push_back(mk(32'h10, 32'h0,        32'h0,   0, 0, 0, 1,   0, 0, 32'h4));
    vecs.push_back(mk(32'hFC, 32'h0,        32'h0,   0, 0, 0, 1,   0, 0, 32'h4));

    // Reset and sweep every table entry while held in reset.
    reset_0 = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 64; i++) begin
      bp_bus.pc_if = 32'(i * 4);
      #1;
      chk($sformatf("reset_taken[%0d]", i), {31'b0, bp_bus.taken_if}, 32'h0);
    end
    chk("reset_branch_cnt", {28'b0, bp_bus.branch_cnt}, 32'h0);
    chk("reset_miss_cnt",   {28'b0, bp_bus.miss_cnt},   32'h0);
    chk("reset_redirect",   {31'b0, bp_bus.redirect},   32'h0);
    @(negedge clock);
    reset_0 = 1'b1;
    @(posedge clock);
    #1;

    // Vector table: inputs at posedge+1, combinational checks at negedge.
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].pc_if, vecs[k].pc_ex, vecs[k].tgt, vecs[k].br, vecs[k].bpt, vecs[k].act, vecs[k].vld);
      @(negedge clock);
      chk($sformatf("v%0d_taken", k),    {31'b0, bp_bus.taken_if}, {31'b0, vecs[k].exp_t});
      chk($sformatf("v%0d_redirect", k), {31'b0, bp_bus.redirect}, {31'b0, vecs[k].exp_r});
      chk($sformatf("v%0d_rpc", k),      bp_bus.redirect_pc,       vecs[k].exp_pc);
      @(posedge clock);
      #1;
    end
    chk("tbl_branch_cnt", {28'b0, bp_bus.branch_cnt}, 32'd10);
    chk("tbl_miss_cnt",   {28'b0, bp_bus.miss_cnt},   32'd8);

    // Same index read and trained in one cycle: old value now, new value next cycle.
    drive(32'h80, 32'h80, 32'h1000, 1, 0, 1, 1);
    @(negedge clock);
    chk("hazard_taken_now", {31'b0, bp_bus.taken_if}, 32'h0);
    chk("hazard_redirect",  {31'b0, bp_bus.redirect}, 32'h1);
    chk("hazard_rpc",       bp_bus.redirect_pc,       32'h1000);
    @(posedge clock);
    #1;
    drive(32'h80, 32'h0, 32'h0, 0, 0, 0, 1);
    @(negedge clock);
    chk("hazard_taken_next", {31'b0, bp_bus.taken_if}, 32'h1);
    @(posedge clock);
    #1;

    // Invalid EX slot with a mismatched branch: no redirect, no training, no stats.
    for (int k = 0; k < 3; k++) begin
      drive(32'h80, 32'h80, 32'h1000, 1, 1, 0, 0);
      @(negedge clock);
      chk($sformatf("bubble%0d_redirect", k), {31'b0, bp_bus.redirect}, 32'h0);
      chk($sformatf("bubble%0d_rpc", k),      bp_bus.redirect_pc,       32'h84);
      @(posedge clock);
      #1;
    end
    chk("bubble_taken",      {31'b0, bp_bus.taken_if},   32'h1);
    chk("bubble_branch_cnt", {28'b0, bp_bus.branch_cnt}, 32'd11);
    chk("bubble_miss_cnt",   {28'b0, bp_bus.miss_cnt},   32'd9);

    // Statistics saturation: 20 more mispredicted branches starting at 11/9.
    for (int k = 1; k <= 20; k++) begin
      drive(32'h80, 32'h200, 32'h400, 1, 0, 1, 1);
      @(negedge clock);
      chk($sformatf("stat%0d_redirect", k), {31'b0, bp_bus.redirect}, 32'h1);
      @(posedge clock);
      #1;
      if (k == 4) begin
        chk("stat4_branch_cnt", {28'b0, bp_bus.branch_cnt}, 32'd15);
        chk("stat4_miss_cnt",   {28'b0, bp_bus.miss_cnt},   32'd13);
      end
    end
    chk("stat_branch_sat", {28'b0, bp_bus.branch_cnt}, 32'd15);
    chk("stat_miss_sat",   {28'b0, bp_bus.miss_cnt},   32'd15);

    // Asynchronous reset mid-training discards everything immediately.
    drive(32'h80, 32'h200, 32'h400, 1, 0, 1, 1);
    #1;
    reset_0 = 1'b0;
    #1;
    chk("arst_taken_80",    {31'b0, bp_bus.taken_if},   32'h0);
    chk("arst_branch_cnt",  {28'b0, bp_bus.branch_cnt}, 32'h0);
    chk("arst_miss_cnt",    {28'b0, bp_bus.miss_cnt},   32'h0);
    bp_bus.pc_if = 32'h200;
    #1;
    chk("arst_taken_200",   {31'b0, bp_bus.taken_if},   32'h0);
    bp_bus.pc_if = 32'h20;
    bp_bus.valid_ex = 1'b0;
    #1;
    chk("arst_taken_20",    {31'b0, bp_bus.taken_if},   32'h0);
    chk("arst_redirect",    {31'b0, bp_bus.redirect},   32'h0);
    @(negedge clock);
    reset_0 = 1'b1;

    // First edge after reset release trains normally.
    drive(32'h80, 32'h80, 32'h1000, 1, 0, 1, 1);
    @(posedge clock);
    #1;
    drive(32'h80, 32'h0, 32'h0, 0, 0, 0, 0);
    @(negedge clock);
    chk("post_rst_taken",      {31'b0, bp_bus.taken_if},   32'h1);
    chk("post_rst_branch_cnt", {28'b0, bp_bus.branch_cnt}, 32'd1);
    chk("post_rst_miss_cnt",   {28'b0, bp_bus.miss_cnt},   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
